// File: rtl/msk_frame_sync.sv
// Frame synchroniser for the MSK hard-bit stream.
// Correlates incoming bits against a sync word (true or inverted polarity),
// confirms the frame timing over several syncs, then flywheels through
// occasional missed syncs while emitting polarity-corrected payload bits.
module msk_frame_sync #(
    parameter int                SYNC_W     = 32,
    parameter logic [SYNC_W-1:0] SYNC_WORD  = 32'h1ACF_FC1D,
    parameter int                FRAME_LEN  = 256,
    parameter int                MAX_ERR    = 2,
    parameter int                LOCK_ERR   = 4,
    parameter int                VERIFY_CNT = 2,
    parameter int                MISS_CNT   = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          data_i,
    input  logic                          data_val_i,
    output logic                          payload_o,
    output logic                          payload_val_o,
    output logic                          sof_o,
    output logic                          eof_o,
    output logic                          locked_o,
    output logic                          inverted_o,
    output logic                          sync_hit_o,
    output logic [$clog2(SYNC_W+1)-1:0]   sync_err_o
);

    localparam int ERR_W    = $clog2(SYNC_W + 1);
    localparam int CNT_W    = $clog2(FRAME_LEN + SYNC_W);
    localparam int HIT_W    = $clog2(VERIFY_CNT + 1);
    localparam int MISS_W   = $clog2(MISS_CNT + 1);
    localparam int CHECK_PT = FRAME_LEN + SYNC_W - 1;

    localparam logic [ERR_W-1:0]  MAX_ERR_V    = ERR_W'(MAX_ERR);
    localparam logic [ERR_W-1:0]  LOCK_ERR_V   = ERR_W'(LOCK_ERR);
    localparam logic [ERR_W-1:0]  SYNC_W_V     = ERR_W'(SYNC_W);
    localparam logic [CNT_W-1:0]  CHECK_PT_V   = CNT_W'(CHECK_PT);
    localparam logic [CNT_W-1:0]  FRAME_LEN_V  = CNT_W'(FRAME_LEN);
    localparam logic [CNT_W-1:0]  LAST_PAY_V   = CNT_W'(FRAME_LEN - 1);
    localparam logic [HIT_W-1:0]  VERIFY_CNT_V = HIT_W'(VERIFY_CNT);
    localparam logic [MISS_W-1:0] MISS_CNT_V   = MISS_W'(MISS_CNT);

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t              state_reg;
    logic [SYNC_W-1:0]   win_reg;
    logic [CNT_W-1:0]    bit_cnt_reg;
    logic [HIT_W-1:0]    hit_cnt_reg;
    logic [MISS_W-1:0]   miss_cnt_reg;

    logic [SYNC_W-1:0]   win_next;
    logic [SYNC_W-1:0]   diff;
    logic [ERR_W-1:0]    d_t;
    logic [ERR_W-1:0]    d_i;
    logic [ERR_W-1:0]    dist_lat;
    logic                true_hit;
    logic                inv_hit;
    logic                at_check;
    logic [HIT_W-1:0]    hit_inc;
    logic [MISS_W-1:0]   miss_inc;

    // Window as it will look once the current bit is shifted in (newest at LSB)
    assign win_next = {win_reg[SYNC_W-2:0], data_i};

    generate
        for (genvar gi = 0; gi < SYNC_W; gi++) begin : g_diff
            assign diff[gi] = win_next[gi] ^ SYNC_WORD[gi];
        end
    endgenerate

    // Hamming distances to the sync word and to its complement
    always_comb begin
        d_t = '0;
        for (int i = 0; i < SYNC_W; i++) begin
            d_t = d_t + ERR_W'(diff[i]);
        end
        d_i = SYNC_W_V - d_t;
    end

    // Once a polarity is latched, only that polarity is scored at check points
    assign dist_lat = inverted_o ? d_i : d_t;
    assign true_hit = (d_t <= MAX_ERR_V);
    assign inv_hit  = (d_i <= MAX_ERR_V);
    assign at_check = (bit_cnt_reg == CHECK_PT_V);
    assign hit_inc  = hit_cnt_reg + HIT_W'(1);
    assign miss_inc = miss_cnt_reg + MISS_W'(1);

    // Search / verify / lock state machine with registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= SEARCH;
            win_reg       <= '0;
            bit_cnt_reg   <= '0;
            hit_cnt_reg   <= '0;
            miss_cnt_reg  <= '0;
            payload_o     <= 1'b0;
            payload_val_o <= 1'b0;
            sof_o         <= 1'b0;
            eof_o         <= 1'b0;
            locked_o      <= 1'b0;
            inverted_o    <= 1'b0;
            sync_hit_o    <= 1'b0;
            sync_err_o    <= '0;
        end else begin
            sync_hit_o    <= 1'b0;
            payload_val_o <= 1'b0;
            sof_o         <= 1'b0;
            eof_o         <= 1'b0;
            if (data_val_i) begin
                win_reg <= win_next;
                case (state_reg)
                    SEARCH: begin
                        sync_err_o <= (d_t <= d_i) ? d_t : d_i;
                        if (true_hit || inv_hit) begin
                            // True polarity takes precedence when both qualify
                            sync_hit_o   <= 1'b1;
                            inverted_o   <= !true_hit;
                            bit_cnt_reg  <= '0;
                            hit_cnt_reg  <= HIT_W'(1);
                            miss_cnt_reg <= '0;
                            if (VERIFY_CNT == 1) begin
                                state_reg <= LOCKED;
                                locked_o  <= 1'b1;
                            end else begin
                                state_reg <= VERIFY;
                            end
                        end
                    end
                    VERIFY: begin
                        if (at_check) begin
                            bit_cnt_reg <= '0;
                            sync_err_o  <= dist_lat;
                            if (dist_lat <= MAX_ERR_V) begin
                                sync_hit_o  <= 1'b1;
                                hit_cnt_reg <= hit_inc;
                                if (hit_inc == VERIFY_CNT_V) begin
                                    state_reg    <= LOCKED;
                                    locked_o     <= 1'b1;
                                    miss_cnt_reg <= '0;
                                end
                            end else begin
                                state_reg  <= SEARCH;
                                inverted_o <= 1'b0;
                            end
                        end else begin
                            bit_cnt_reg <= bit_cnt_reg + CNT_W'(1);
                        end
                    end
                    LOCKED: begin
                        if (at_check) begin
                            bit_cnt_reg <= '0;
                            sync_err_o  <= dist_lat;
                            if (dist_lat <= LOCK_ERR_V) begin
                                sync_hit_o   <= 1'b1;
                                miss_cnt_reg <= '0;
                            end else if (miss_inc == MISS_CNT_V) begin
                                state_reg    <= SEARCH;
                                locked_o     <= 1'b0;
                                inverted_o   <= 1'b0;
                                miss_cnt_reg <= '0;
                            end else begin
                                miss_cnt_reg <= miss_inc;
                            end
                        end else begin
                            bit_cnt_reg <= bit_cnt_reg + CNT_W'(1);
                            if (bit_cnt_reg < FRAME_LEN_V) begin
                                payload_val_o <= 1'b1;
                                payload_o     <= data_i ^ inverted_o;
                                sof_o         <= (bit_cnt_reg == '0);
                                eof_o         <= (bit_cnt_reg == LAST_PAY_V);
                            end
                        end
                    end
                    default: begin
                        state_reg <= SEARCH;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_msk_frame_sync.sv
// Scoreboard bench for msk_frame_sync: stimulus is built from whole frames,
// the expected output events are derived from the frame plan and queued, and
// a monitor process pops and compares whenever the DUT emits a bit or a hit.
`timescale 1ns/1ps
module tb_msk_frame_sync;

    localparam int          SYNC_W    = 32;
    localparam logic [31:0] SYNC_WORD = 32'h1ACF_FC1D;
    localparam int          FRAME_LEN = 256;
    localparam int          ERR_W     = 6;

    logic             clk = 1'b0;
    logic             rst;
    logic             data_i;
    logic             data_val_i;
    logic             payload_o;
    logic             payload_val_o;
    logic             sof_o;
    logic             eof_o;
    logic             locked_o;
    logic             inverted_o;
    logic             sync_hit_o;
    logic [ERR_W-1:0] sync_err_o;

    msk_frame_sync dut (
        .clk           (clk),
        .rst           (rst),
        .data_i        (data_i),
        .data_val_i    (data_val_i),
        .payload_o     (payload_o),
        .payload_val_o (payload_val_o),
        .sof_o         (sof_o),
        .eof_o         (eof_o),
        .locked_o      (locked_o),
        .inverted_o    (inverted_o),
        .sync_hit_o    (sync_hit_o),
        .sync_err_o    (sync_err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit is_hit;
        bit b;
        bit sof;
        bit eof;
        int err;
        bit lck;
        bit inv;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   n_pv = 0, n_sof = 0, n_eof = 0, n_hit = 0;
    int   duty = 100;
    bit   pay [0:5][0:FRAME_LEN-1];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h t=%0t", name, got, want, $time);
        end
    endtask

    task automatic new_payloads();
        for (int f = 0; f < 6; f++)
            for (int i = 0; i < FRAME_LEN; i++)
                pay[f][i] = 1'($urandom_range(0, 1));
    endtask

    function automatic logic [31:0] err_mask(input int k);
        logic [31:0] m = '0;
        while ($countones(m) < k) m[$urandom_range(0, 31)] = 1'b1;
        return m;
    endfunction

    // One valid bit, preceded by random-length gaps when duty < 100
    task automatic send_bit(input bit b);
        while (int'($urandom_range(0, 99)) >= duty) begin
            data_val_i = 1'b0;
            data_i     = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
        data_val_i = 1'b1;
        data_i     = b;
        @(posedge clk); #1;
        data_val_i = 1'b0;
    endtask

    task automatic send_sync(input logic [31:0] w);
        for (int i = SYNC_W - 1; i >= 0; i--) send_bit(w[i]);
    endtask

    task automatic send_pay(input int f, input int lo, input int hi, input bit inv);
        for (int i = lo; i < hi; i++) send_bit(pay[f][i] ^ inv);
    endtask

    task automatic exp_hit(input int err, input bit lck, input bit inv);
        exp_t e;
        e.is_hit = 1'b1; e.b = 1'b0; e.sof = 1'b0; e.eof = 1'b0;
        e.err = err; e.lck = lck; e.inv = inv;
        exp_q.push_back(e);
    endtask

    task automatic exp_pay(input int f, input int lo, input int hi, input bit inv);
        exp_t e;
        for (int i = lo; i < hi; i++) begin
            e.is_hit = 1'b0; e.b = pay[f][i];
            e.sof = (i == 0); e.eof = (i == FRAME_LEN - 1);
            e.err = 0; e.lck = 1'b1; e.inv = inv;
            exp_q.push_back(e);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        data_val_i = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        check("reset_outputs",
              {payload_o, payload_val_o, sof_o, eof_o, locked_o, inverted_o, sync_hit_o, sync_err_o},
              64'd0);
    endtask

    task automatic drain(input string name, input int pv0, input int sof0, input int eof0,
                         input int hit0, input int sofs, input int eofs, input int pvs, input int hits);
        data_val_i = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check({name, "_queue_left"}, exp_q.size(), 0);
        check({name, "_payload_count"}, n_pv - pv0, pvs);
        check({name, "_sof_count"}, n_sof - sof0, sofs);
        check({name, "_eof_count"}, n_eof - eof0, eofs);
        check({name, "_hit_count"}, n_hit - hit0, hits);
        $display("test %s: payload=%0d sof=%0d eof=%0d hits=%0d", name,
                 n_pv - pv0, n_sof - sof0, n_eof - eof0, n_hit - hit0);
    endtask

    // Four clean frames, optionally inverted on the line
    task automatic run_clean(input string name, input bit inv);
        int pv0, sof0, eof0, hit0;
        do_reset();
        pv0 = n_pv; sof0 = n_sof; eof0 = n_eof; hit0 = n_hit;
        exp_hit(0, 1'b0, inv);
        exp_hit(0, 1'b1, inv);
        exp_pay(1, 0, FRAME_LEN, inv);
        exp_hit(0, 1'b1, inv);
        exp_pay(2, 0, FRAME_LEN, inv);
        exp_hit(0, 1'b1, inv);
        exp_pay(3, 0, FRAME_LEN, inv);
        for (int f = 0; f < 4; f++) begin
            send_sync(inv ? ~SYNC_WORD : SYNC_WORD);
            if (f == 0) check({name, "_locked_after_sync0"}, locked_o, 1'b0);
            if (f == 1) check({name, "_locked_after_sync1"}, {locked_o, inverted_o}, {1'b1, inv});
            send_pay(f, 0, FRAME_LEN, inv);
        end
        drain(name, pv0, sof0, eof0, hit0, 3, 3, 3 * FRAME_LEN, 4);
    endtask

    // Scoreboard monitor, sampling on the falling edge
    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (payload_val_o === 1'b1 || sync_hit_o === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_output", {payload_val_o, sync_hit_o}, 2'b00);
                end else begin
                    e = exp_q.pop_front();
                    if (e.is_hit) begin
                        check("sync_hit",
                              {sync_hit_o, payload_val_o, locked_o, inverted_o, sync_err_o},
                              {1'b1, 1'b0, e.lck, e.inv, ERR_W'(e.err)});
                        $display("hit err=%0d locked=%0d inverted=%0d t=%0t",
                                 sync_err_o, locked_o, inverted_o, $time);
                    end else begin
                        check("payload",
                              {payload_val_o, sync_hit_o, payload_o, sof_o, eof_o, inverted_o, locked_o},
                              {1'b1, 1'b0, e.b, e.sof, e.eof, e.inv, 1'b1});
                        if (eof_o) $display("frame complete t=%0t", $time);
                    end
                end
            end
            if (payload_val_o === 1'b1) n_pv++;
            if (sof_o === 1'b1) n_sof++;
            if (eof_o === 1'b1) n_eof++;
            if (sync_hit_o === 1'b1) n_hit++;
        end
    endtask

    initial begin
        #(300000);
        $display("FAIL watchdog_timeout t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int pv0, sof0, eof0, hit0;
        logic [31:0] m2, m3, m4, m5, m3s;
        rst = 1'b1;
        data_i = 1'b0;
        data_val_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        fork
            monitor();
        join_none

        // Clean stream, then the same stream with 50% valid duty
        new_payloads();
        duty = 100;
        run_clean("clean", 1'b0);
        duty = 50;
        run_clean("gapped", 1'b0);
        duty = 100;

        // Inverted line polarity
        new_payloads();
        run_clean("inverted", 1'b1);

        // Sync errors while locked: tolerated, then three misses drop lock
        new_payloads();
        do_reset();
        pv0 = n_pv; sof0 = n_sof; eof0 = n_eof; hit0 = n_hit;
        m2 = err_mask(2); m3 = err_mask(5); m4 = err_mask(5); m5 = err_mask(5);
        exp_hit(0, 1'b0, 1'b0);
        exp_hit(0, 1'b1, 1'b0);
        exp_pay(1, 0, FRAME_LEN, 1'b0);
        exp_hit(2, 1'b1, 1'b0);
        exp_pay(2, 0, FRAME_LEN, 1'b0);
        exp_pay(3, 0, FRAME_LEN, 1'b0);
        exp_pay(4, 0, FRAME_LEN, 1'b0);
        send_sync(SYNC_WORD); send_pay(0, 0, FRAME_LEN, 1'b0);
        send_sync(SYNC_WORD); send_pay(1, 0, FRAME_LEN, 1'b0);
        send_sync(SYNC_WORD ^ m2);
        check("errs_sync2", {locked_o, sync_err_o}, {1'b1, ERR_W'(2)});
        send_pay(2, 0, FRAME_LEN, 1'b0);
        send_sync(SYNC_WORD ^ m3);
        check("errs_sync3", {locked_o, sync_hit_o, sync_err_o}, {1'b1, 1'b0, ERR_W'(5)});
        send_pay(3, 0, FRAME_LEN, 1'b0);
        send_sync(SYNC_WORD ^ m4);
        check("errs_sync4", {locked_o, sync_hit_o}, {1'b1, 1'b0});
        send_pay(4, 0, FRAME_LEN, 1'b0);
        send_sync(SYNC_WORD ^ m5);
        check("errs_sync5_unlock", {locked_o, inverted_o, sync_hit_o}, 3'b000);
        send_pay(5, 0, FRAME_LEN, 1'b0);
        drain("errors", pv0, sof0, eof0, hit0, 4, 4, 4 * FRAME_LEN, 3);

        // Search threshold: 3 errors rejected, 2 errors accepted
        do_reset();
        pv0 = n_pv; sof0 = n_sof; eof0 = n_eof; hit0 = n_hit;
        m3s = err_mask(3);
        send_sync(SYNC_WORD ^ m3s);
        check("search_3err_no_hit", n_hit - hit0, 0);
        for (int i = 0; i < 8; i++) send_bit(1'($urandom_range(0, 1)));
        m2 = err_mask(2);
        exp_hit(2, 1'b0, 1'b0);
        send_sync(SYNC_WORD ^ m2);
        check("search_2err_hit", {sync_hit_o, sync_err_o}, {1'b1, ERR_W'(2)});
        drain("search", pv0, sof0, eof0, hit0, 0, 0, 0, 1);

        // Reset mid-payload of frame 2, then relock on the following syncs
        new_payloads();
        do_reset();
        pv0 = n_pv; sof0 = n_sof; eof0 = n_eof; hit0 = n_hit;
        exp_hit(0, 1'b0, 1'b0);
        exp_hit(0, 1'b1, 1'b0);
        exp_pay(1, 0, FRAME_LEN, 1'b0);
        exp_hit(0, 1'b1, 1'b0);
        exp_pay(2, 0, FRAME_LEN / 2, 1'b0);
        send_sync(SYNC_WORD); send_pay(0, 0, FRAME_LEN, 1'b0);
        send_sync(SYNC_WORD); send_pay(1, 0, FRAME_LEN, 1'b0);
        send_sync(SYNC_WORD); send_pay(2, 0, FRAME_LEN / 2, 1'b0);
        do_reset();
        check("midreset_queue_left", exp_q.size(), 0);
        exp_hit(0, 1'b0, 1'b0);
        exp_hit(0, 1'b1, 1'b0);
        exp_pay(4, 0, FRAME_LEN, 1'b0);
        exp_hit(0, 1'b1, 1'b0);
        exp_pay(5, 0, FRAME_LEN, 1'b0);
        send_pay(2, FRAME_LEN / 2, FRAME_LEN, 1'b0);
        send_sync(SYNC_WORD); send_pay(3, 0, FRAME_LEN, 1'b0);
        send_sync(SYNC_WORD);
        check("midreset_relock", locked_o, 1'b1);
        send_pay(4, 0, FRAME_LEN, 1'b0);
        send_sync(SYNC_WORD); send_pay(5, 0, FRAME_LEN, 1'b0);
        drain("midreset", pv0, sof0, eof0, hit0, 4, 3, 3 * FRAME_LEN + FRAME_LEN / 2, 6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
